// File: rtl/logic_unit_seq.sv
// ---------------------------------------------------------------------------
// logic_unit_seq
//   Multi-cycle bitwise logic unit (AND / OR / XOR / NOR) for the ALU logic
//   slice. Operands are captured on a start handshake and processed CHUNK
//   bits per clock, LSB first. The result register holds the previous value
//   until the completion edge of the next operation.
//
// Parameters
//   WIDTH  operand/result width (must be a multiple of CHUNK)
//   CHUNK  bits processed per clock; N = WIDTH/CHUNK cycles per operation
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, accepted in IDLE or DONE
//   op     in   2      00 AND, 01 OR, 10 XOR, 11 NOR (sampled with start)
//   inp1   in   WIDTH  operand A (sampled with start)
//   inp2   in   WIDTH  operand B (sampled with start)
//   busy   out  1      high while an operation is in flight
//   done   out  1      one-cycle completion pulse
//   out    out  WIDTH  result register
//   zero   out  1      result-is-zero flag (only with LOGIC_ZERO_FLAG_EN)
//
// Build option
//   LOGIC_ZERO_FLAG_EN  adds the registered zero flag output.
// ---------------------------------------------------------------------------
module logic_unit_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
`ifdef LOGIC_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Reject configurations where the width does not split into whole chunks.
  generate
    if ((CHUNK == 0) || ((WIDTH % ((CHUNK == 0) ? 1 : CHUNK)) != 0)) begin : g_bad_cfg
      $error("logic_unit_seq: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef LOGIC_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic [CHUNK-1:0] a_chunk_c;
  logic [CHUNK-1:0] b_chunk_c;
  logic [CHUNK-1:0] res_chunk_c;

  // Operand registers are shifted right each BUSY cycle, so the active chunk
  // always sits in the low CHUNK bits.
  assign a_chunk_c = a_q[CHUNK-1:0];
  assign b_chunk_c = b_q[CHUNK-1:0];

  // Per-chunk logic function on the latched op.
  always_comb begin
    res_chunk_c = '0;
    unique case (op_q)
      OP_AND:  res_chunk_c = a_chunk_c & b_chunk_c;
      OP_OR:   res_chunk_c = a_chunk_c | b_chunk_c;
      OP_XOR:  res_chunk_c = a_chunk_c ^ b_chunk_c;
      OP_NOR:  res_chunk_c = ~(a_chunk_c | b_chunk_c);
      default: res_chunk_c = '0;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef LOGIC_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = inp1;
          b_d     = inp2;
          op_d    = op;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BUSY: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        // New chunk enters at the top; after N cycles chunk 0 reaches bit 0.
        acc_d = (acc_q >> CHUNK) | (WIDTH'(res_chunk_c) << (WIDTH - CHUNK));
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          out_d   = acc_d;
`ifdef LOGIC_ZERO_FLAG_EN
          zero_d  = (acc_d == '0);
`endif
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_BUSY);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef LOGIC_ZERO_FLAG_EN
  // Zero flag register, updated with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule
